hwpe_ctrl_regfile_reader: RTL
=============================

HWPE_CTRL_REGFILE_READER -- requirements
Module: hwpe_ctrl_regfile_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning the register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the register-file word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous soft clear, active high.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin a readout.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH bits: first word address, sampled with start.
REQ-008 SHALL have port num_words, input, ADDR_WIDTH+1 bits: word count, sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high while a readout is active.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port rf_re, output, 1 bit: register-file ReadEnable.
REQ-012 SHALL have port rf_raddr, output, ADDR_WIDTH bits: register-file ReadAddr.
REQ-013 SHALL have port rf_rdata, input, DATA_WIDTH bits: register-file ReadData, valid the cycle after rf_re.
REQ-014 SHALL have port out_valid, output, 1 bit: output stream valid.
REQ-015 SHALL have port out_ready, input, 1 bit: output stream ready.
REQ-016 SHALL have port out_data, output, DATA_WIDTH bits: output stream word.
REQ-017 SHALL have port out_last, output, 1 bit: marks the final word of a readout.

Function
REQ-018 SHALL implement FSM states IDLE, READ and DRAIN.
REQ-019 IDLE->READ SHALL occur on start with num_words>0; IDLE SHALL ignore start with num_words==0 except for a done pulse in the next cycle.
REQ-020 READ->DRAIN SHALL occur in the cycle after the last rf_re issues; DRAIN->IDLE SHALL occur on the out_valid&out_ready handshake of the out_last word.
REQ-021 start SHALL be ignored while busy.
REQ-022 Word i SHALL be read at (base_addr+i) mod 2**ADDR_WIDTH, so address wrap-around is silent.
REQ-023 rf_re SHALL be asserted in READ only when fifo_count+inflight<3, where inflight is rf_re of the previous cycle.
REQ-024 rf_raddr SHALL be held stable when rf_re is low.
REQ-025 rf_rdata SHALL be written into an internal 3-entry FIFO in the cycle after each rf_re.
REQ-026 out_* SHALL be driven from the FIFO head, with out_last set on entry num_words-1.
REQ-027 Latency: start in cycle 0 gives rf_re in cycle 1 and the first out_valid in cycle 3.
REQ-028 Throughput SHALL be one word per cycle with out_ready held high.
REQ-029 out_valid, once high, SHALL stay high with out_data stable until the handshake.
REQ-030 The FIFO SHALL never overflow under arbitrary out_ready patterns.
REQ-031 done SHALL pulse exactly one cycle after the out_last handshake; busy SHALL fall in that same cycle.
REQ-032 num_words==2**ADDR_WIDTH SHALL read every word once.
REQ-033 clear SHALL return the FSM to IDLE, flush the FIFO and inflight state, and deassert rf_re and out_valid in the next cycle, with no done pulse.
REQ-034 If clear and start are high in the same cycle, clear SHALL win.

Reset
REQ-035 On rst_n low the FSM SHALL enter IDLE asynchronously.
REQ-036 On reset, all counters and FIFO pointers SHALL be 0.
REQ-037 On reset, busy, done, rf_re, out_valid and out_last SHALL be 0.
REQ-038 On reset, rf_raddr and out_data SHALL be 0.
REQ-039 Reset mid-readout SHALL discard all pending words.

Structure
REQ-040 The FSM state enum SHALL be placed in hwpe_ctrl_package as regfile_reader_state_t.
REQ-041 The FIFO depth constant SHALL be placed in hwpe_ctrl_package as REGFILE_READER_FIFO_DEPTH=3.
REQ-042 The FIFO SHALL be one sub-module, hwpe_ctrl_regfile_reader_fifo, with flop storage and valid/ready on both sides.
REQ-043 The bench SHALL pair the block with the latch register file model.

Verification
REQ-044 Preload words k=0x1000+k; start with base 4, num 3 and out_ready=1 -> data 0x1004, 0x1005, 0x1006, out_last on the 3rd, done in the cycle after.
REQ-045 base 30, num 4 -> addresses 30, 31, 0, 1 and data 0x101E, 0x101F, 0x1000, 0x1001.
REQ-046 num 32 with out_ready toggled 1010... -> all 32 words in order, rf_re never with fifo_count+inflight=3, out_data stable while stalled.
REQ-047 num 0 -> no rf_re and no out_valid, one done pulse in the next cycle.
REQ-048 clear asserted mid-readout after 5 words -> idle next cycle, no done; a following readout of base 0, num 2 -> 0x1000, 0x1001.
REQ-049 start pulsed while busy -> ignored, with word count and addresses unchanged.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared types and constants for the hwpe_ctrl register-file reader.
package hwpe_ctrl_package;

  localparam int REGFILE_READER_FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } regfile_reader_state_t;

endpackage

// File: rtl/hwpe_ctrl_regfile_reader_fifo.sv
// Small flop-based FIFO with valid/ready on both sides and a soft clear.
module hwpe_ctrl_regfile_reader_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clear,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [WIDTH-1:0]               i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_ready = (r_count != CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage is reset so an empty FIFO presents zero on o_data.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_mem[gi] <= '0;
        else if (w_push && (r_wr_ptr == PW'(gi)))    r_mem[gi] <= i_data;
      end
    end
  endgenerate

endmodule

// File: rtl/hwpe_ctrl_regfile_reader.sv
// Streams a contiguous (wrapping) range of register-file words out through
// a small FIFO, throttling reads so returned data always has room.
module hwpe_ctrl_regfile_reader
  import hwpe_ctrl_package::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_re,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int DEPTH = REGFILE_READER_FIFO_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  regfile_reader_state_t r_state;
  regfile_reader_state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_num;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_popped;
  logic                  r_inflight;
  logic                  r_done;

  logic                  w_rf_re;
  logic                  w_accept;
  logic                  w_empty_start;
  logic                  w_fifo_in_ready;
  logic                  w_fifo_out_valid;
  logic                  w_handshake;
  logic                  w_last;
  logic                  w_last_hs;
  logic [CW-1:0]         w_fifo_count;
  logic [CW:0]           w_occupancy;

  assign w_accept      = start && (r_state == IDLE) && (num_words != '0);
  assign w_empty_start = start && (r_state == IDLE) && (num_words == '0);
  // A read still in flight already owns a FIFO slot.
  assign w_occupancy   = (CW+1)'(w_fifo_count) + (CW+1)'(r_inflight);
  assign w_handshake   = w_fifo_out_valid && out_ready;
  assign w_last        = w_fifo_out_valid && (r_popped == r_num - 1'b1);
  assign w_last_hs     = w_handshake && w_last;

  always_comb begin
    w_state_next = r_state;
    w_rf_re      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = READ;
      end
      READ: begin
        w_rf_re = (r_issued != r_num) && w_fifo_in_ready &&
                  (w_occupancy < (CW+1)'(DEPTH));
        if (w_rf_re && ((r_issued + 1'b1) == r_num)) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_last_hs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (clear) begin
        r_issued   <= '0;
        r_popped   <= '0;
        r_inflight <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        r_inflight <= w_rf_re;
        r_done     <= w_last_hs || w_empty_start;
        if (w_accept) begin
          r_num    <= num_words;
          r_addr   <= base_addr;
          r_issued <= '0;
          r_popped <= '0;
        end else begin
          if (w_rf_re) begin
            r_addr   <= r_addr + 1'b1;
            r_issued <= r_issued + 1'b1;
          end
          if (w_handshake) r_popped <= r_popped + 1'b1;
        end
      end
    end
  end

  hwpe_ctrl_regfile_reader_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_valid (r_inflight),
    .o_ready (w_fifo_in_ready),
    .i_data  (rf_rdata),
    .o_valid (w_fifo_out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_count (w_fifo_count)
  );

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign rf_re     = w_rf_re;
  assign rf_raddr  = r_addr;
  assign out_valid = w_fifo_out_valid;
  assign out_last  = w_last;

endmodule
